// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs one request at a time against a
// variable-latency instruction memory, and presents the fetched word to IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_IF,
  output logic [31:0] pc4_IF,
  output logic [31:0] Instr_IF,
  output logic        fetch_stall
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HAVE = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] buf_q;
  logic        buf_valid_q;
  logic        drop_q;

  logic [31:0] pc_inc_d;
  logic [31:0] redirect_tgt_d;
  logic        handshake_d;

  assign pc_inc_d       = pc_q + 32'd4;
  assign redirect_tgt_d = redirect_pc & 32'hFFFF_FFFC;

  // The request is gated by redirect so a stale address is never handed to memory.
  assign imem_req    = (state_q == S_REQ) && !redirect && !rst;
  assign handshake_d = imem_req && imem_ready;

  assign imem_addr   = pc_q;
  assign pc_IF       = pc_q;
  assign pc4_IF      = pc_inc_d;
  assign Instr_IF    = buf_valid_q ? buf_q : NOP_INSTR;
  assign fetch_stall = !buf_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      state_q     <= S_REQ;
      buf_q       <= NOP_INSTR;
      buf_valid_q <= 1'b0;
      drop_q      <= 1'b0;
    end else if (redirect) begin
      pc_q <= redirect_tgt_d;
      case (state_q)
        S_WAIT: begin
          // A response landing this cycle is for the old path; otherwise
          // remember to throw the next one away.
          if (imem_rvalid) begin
            drop_q  <= 1'b0;
            state_q <= S_REQ;
          end else begin
            drop_q <= 1'b1;
          end
        end
        S_HAVE: begin
          buf_valid_q <= 1'b0;
          state_q     <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (handshake_d) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              buf_q       <= imem_rdata;
              buf_valid_q <= 1'b1;
              state_q     <= S_HAVE;
            end
          end
        end
        S_HAVE: begin
          if (!stall_in) begin
            pc_q        <= pc_inc_d;
            buf_valid_q <= 1'b0;
            state_q     <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: a transaction-level model (PC, presented
// word, queue of outstanding requests with a stale flag) predicts every output.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_IF;
  logic [31:0] pc4_IF;
  logic [31:0] Instr_IF;
  logic        fetch_stall;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  if_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_IF(pc_IF), .pc4_IF(pc4_IF), .Instr_IF(Instr_IF), .fetch_stall(fetch_stall)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp, input int cyc);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0103;
      1: return 32'hFFFF_FFFC;
      2: return 32'h0000_0100;
      3: return 32'h0000_0200;
      4: return $urandom;
      default: return $urandom & 32'h0000_0FFC;
    endcase
  endfunction

  // Reference model state.
  logic [31:0] m_pc;
  logic        m_have;
  logic [31:0] m_word;
  bit          m_stale_q[$];

  // Memory environment state (one response in flight, then busy).
  logic        mem_pending;
  logic [31:0] mem_addr;
  int          mem_cnt;

  logic        exp_req;
  logic        hs;
  logic [31:0] hs_addr;
  logic        have_before;
  bit          stale;

  initial begin
    rst = 1'b1; stall_in = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    m_pc = RST_PC; m_have = 1'b0; m_word = NOP;
    mem_pending = 1'b0; mem_addr = '0; mem_cnt = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst         = (cyc < 3) || ($urandom_range(0, 99) == 0);
      stall_in    = ($urandom_range(0, 2) == 0);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = pick_target();
      imem_ready  = !mem_pending && ($urandom_range(0, 2) != 0);
      if (mem_pending && mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1000_0000 | mem_addr;
      end else if (!mem_pending && $urandom_range(0, 9) == 0) begin
        imem_rvalid = 1'b1;   // stray response: nothing is outstanding
        imem_rdata  = $urandom;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end
      #1;

      exp_req = !rst && !redirect && !m_have && (m_stale_q.size() == 0);
      check("imem_req",    {31'd0, imem_req},    {31'd0, exp_req},    cyc);
      check("imem_addr",   imem_addr,            m_pc,                cyc);
      check("pc_IF",       pc_IF,                m_pc,                cyc);
      check("pc4_IF",      pc4_IF,               m_pc + 32'd4,        cyc);
      check("Instr_IF",    Instr_IF,             m_have ? m_word : NOP, cyc);
      check("fetch_stall", {31'd0, fetch_stall}, {31'd0, !m_have},    cyc);

      hs      = imem_req && imem_ready;
      hs_addr = imem_addr;

      @(posedge clk);
      if (rst) begin
        m_pc = RST_PC;
        m_have = 1'b0;
        m_stale_q.delete();
      end else begin
        have_before = m_have;
        if (imem_rvalid && m_stale_q.size() > 0) begin
          stale = m_stale_q.pop_front();
          if (!stale && !redirect) begin
            m_have = 1'b1;
            m_word = imem_rdata;
          end
        end
        if (redirect) begin
          m_pc = redirect_pc & 32'hFFFF_FFFC;
          m_have = 1'b0;
          foreach (m_stale_q[i]) m_stale_q[i] = 1'b1;
        end else if (have_before && !stall_in) begin
          m_pc = m_pc + 32'd4;
          m_have = 1'b0;
        end
        if (exp_req && imem_ready) m_stale_q.push_back(1'b0);
      end

      if (mem_pending && mem_cnt == 0) mem_pending = 1'b0;
      else if (mem_pending) mem_cnt--;
      if (hs) begin
        mem_pending = 1'b1;
        mem_addr    = hs_addr;
        mem_cnt     = $urandom_range(0, 3);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
